// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light bus monitor: light encodings,
// tracked phases, fault codes and the served-direction marker.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  typedef enum logic [2:0] {
    PH_SYNC    = 3'd0,
    PH_NS_G    = 3'd1,
    PH_NS_Y    = 3'd2,
    PH_EW_G    = 3'd3,
    PH_EW_Y    = 3'd4,
    PH_ALL_RED = 3'd5
  } phase_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ENCODING = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_SEQUENCE = 3'd3;
  localparam logic [2:0] FC_ORDER    = 3'd4;
  localparam logic [2:0] FC_SHORT    = 3'd5;
  localparam logic [2:0] FC_LONG     = 3'd6;
  localparam logic [2:0] FC_STALL    = 3'd7;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_NS   = 2'd1,
    DIR_EW   = 2'd2
  } dir_e;

  function automatic logic light_legal(input logic [2:0] l);
    return (l == LT_RED) || (l == LT_YEL) || (l == LT_GRN);
  endfunction

endpackage

// File: rtl/tlm_dwell_counter.sv
// Phase dwell counter: loads 1 on phase entry, counts unchanged samples,
// saturates at SAT and compares the running value against a min/max window.
module tlm_dwell_counter #(
  parameter int unsigned SAT = 11,
  parameter int unsigned DW  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [DW-1:0] min_val,
  input  logic [DW-1:0] max_val,
  output logic          below_min,
  output logic          at_max
);

  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_d;

  always_comb begin
    dwell_d = dwell_q;
    if (load) begin
      dwell_d = DW'(1'b1);
    end else if (dwell_q < DW'(SAT)) begin
      dwell_d = dwell_q + DW'(1'b1);
    end else begin
      dwell_d = dwell_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q <= {DW{1'b0}};
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign below_min = (dwell_q < min_val);
  assign at_max    = (dwell_q >= max_val);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the NS/EW light bus: tracks the phase sequence and flags
// encoding, conflict, ordering and dwell violations with sticky fault reporting.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned GRN_MIN    = 10,
  parameter int unsigned GRN_MAX    = 10,
  parameter int unsigned YEL_MIN    = 3,
  parameter int unsigned YEL_MAX    = 3,
  parameter int unsigned ALLRED_MAX = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       ns,
  input  logic [2:0]       ew,
  input  logic             fault_clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [2:0]       phase,
  output logic [7:0]       viol_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned GY_MAX    = (GRN_MAX > YEL_MAX) ? GRN_MAX : YEL_MAX;
  localparam int unsigned DWELL_SAT = ((GY_MAX > ALLRED_MAX) ? GY_MAX : ALLRED_MAX) + 1;
  localparam int unsigned DW        = $clog2(DWELL_SAT + 1);

  phase_e           phase_q, phase_d, tr_phase_s;
  dir_e             last_q, last_d, tr_last_s;
  logic             first_q, first_d, tr_first_s;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d, viol_code_s;
  logic [7:0]       viol_q, viol_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             cyc_inc_s, viol_hit_s;
  logic [DW-1:0]    min_s, max_s;
  logic             below_min_s, at_max_s;
  logic             ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;

  assign ns_r = (ns == LT_RED);
  assign ns_y = (ns == LT_YEL);
  assign ns_g = (ns == LT_GRN);
  assign ew_r = (ew == LT_RED);
  assign ew_y = (ew == LT_YEL);
  assign ew_g = (ew == LT_GRN);

  always_comb begin
    min_s = {DW{1'b0}};
    max_s = DW'(DWELL_SAT);
    case (phase_q)
      PH_NS_G, PH_EW_G: begin min_s = DW'(GRN_MIN); max_s = DW'(GRN_MAX); end
      PH_NS_Y, PH_EW_Y: begin min_s = DW'(YEL_MIN); max_s = DW'(YEL_MAX); end
      PH_ALL_RED:       begin min_s = {DW{1'b0}};   max_s = DW'(ALLRED_MAX); end
      default:          begin min_s = {DW{1'b0}};   max_s = DW'(DWELL_SAT); end
    endcase
  end

  tlm_dwell_counter #(.SAT(DWELL_SAT), .DW(DW)) u_dwell (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (phase_d != phase_q),
    .min_val   (min_s),
    .max_val   (max_s),
    .below_min (below_min_s),
    .at_max    (at_max_s)
  );

  // Phase tracking and violation classification; lower codes are tested first.
  always_comb begin
    tr_phase_s  = phase_q;
    tr_last_s   = last_q;
    tr_first_s  = first_q;
    viol_code_s = FC_NONE;
    cyc_inc_s   = 1'b0;
    if (!light_legal(ns) || !light_legal(ew)) begin
      viol_code_s = FC_ENCODING;
    end else if (!ns_r && !ew_r) begin
      viol_code_s = FC_CONFLICT;
    end else begin
      case (phase_q)
        PH_SYNC: begin
          if (ns_g && ew_r) begin
            tr_phase_s = PH_NS_G; tr_first_s = 1'b1;
          end else if (ew_g && ns_r) begin
            tr_phase_s = PH_EW_G; tr_first_s = 1'b1;
          end else begin
            tr_phase_s = PH_SYNC;
          end
        end
        PH_NS_G: begin
          if (ns_g) begin
            if (at_max_s) viol_code_s = FC_LONG; else tr_phase_s = PH_NS_G;
          end else if (ns_y) begin
            if (below_min_s && !first_q) viol_code_s = FC_SHORT;
            else begin tr_phase_s = PH_NS_Y; tr_first_s = 1'b0; end
          end else begin
            viol_code_s = FC_SEQUENCE;
          end
        end
        PH_EW_G: begin
          if (ew_g) begin
            if (at_max_s) viol_code_s = FC_LONG; else tr_phase_s = PH_EW_G;
          end else if (ew_y) begin
            if (below_min_s && !first_q) viol_code_s = FC_SHORT;
            else begin tr_phase_s = PH_EW_Y; tr_first_s = 1'b0; end
          end else begin
            viol_code_s = FC_SEQUENCE;
          end
        end
        PH_NS_Y: begin
          if (ns_y) begin
            if (at_max_s) viol_code_s = FC_LONG; else tr_phase_s = PH_NS_Y;
          end else if (ns_g || ew_y) begin
            viol_code_s = FC_SEQUENCE;
          end else if (below_min_s) begin
            viol_code_s = FC_SHORT;
          end else if (ew_g) begin
            tr_phase_s = PH_EW_G; tr_last_s = DIR_NS;
          end else if (ALLRED_MAX == 0) begin
            viol_code_s = FC_STALL;
          end else begin
            tr_phase_s = PH_ALL_RED; tr_last_s = DIR_NS;
          end
        end
        PH_EW_Y: begin
          if (ew_y) begin
            if (at_max_s) viol_code_s = FC_LONG; else tr_phase_s = PH_EW_Y;
          end else if (ew_g || ns_y) begin
            viol_code_s = FC_SEQUENCE;
          end else if (below_min_s) begin
            viol_code_s = FC_SHORT;
          end else if (ns_g) begin
            tr_phase_s = PH_NS_G; tr_last_s = DIR_EW; cyc_inc_s = 1'b1;
          end else if (ALLRED_MAX == 0) begin
            viol_code_s = FC_STALL;
          end else begin
            tr_phase_s = PH_ALL_RED; tr_last_s = DIR_EW;
          end
        end
        PH_ALL_RED: begin
          if (ns_r && ew_r) begin
            if (at_max_s) viol_code_s = FC_STALL; else tr_phase_s = PH_ALL_RED;
          end else if (ns_g) begin
            if (last_q == DIR_NS) viol_code_s = FC_ORDER;
            else begin tr_phase_s = PH_NS_G; cyc_inc_s = (last_q == DIR_EW); end
          end else if (ew_g) begin
            if (last_q == DIR_EW) viol_code_s = FC_ORDER; else tr_phase_s = PH_EW_G;
          end else begin
            viol_code_s = FC_SEQUENCE;
          end
        end
        default: tr_phase_s = PH_SYNC;
      endcase
    end
  end

  // A violation forces a resync and takes precedence over any fault clear.
  always_comb begin
    viol_hit_s = (viol_code_s != FC_NONE);
    phase_d    = viol_hit_s ? PH_SYNC : tr_phase_s;
    last_d     = viol_hit_s ? last_q  : tr_last_s;
    first_d    = viol_hit_s ? first_q : tr_first_s;
    cyc_d      = (cyc_inc_s && !viol_hit_s) ? cyc_q + CNT_W'(1'b1) : cyc_q;
    viol_d     = (viol_hit_s && (viol_q != 8'hFF)) ? viol_q + 8'd1 : viol_q;
    fault_d    = fault_q;
    code_d     = code_q;
    if (viol_hit_s && (!fault_q || fault_clr)) begin
      fault_d = 1'b1;
      code_d  = viol_code_s;
    end else if (!viol_hit_s && fault_clr) begin
      fault_d = 1'b0;
      code_d  = FC_NONE;
    end else begin
      fault_d = fault_q;
      code_d  = code_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_SYNC;
      last_q  <= DIR_NONE;
      first_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      viol_q  <= 8'd0;
      cyc_q   <= {CNT_W{1'b0}};
    end else begin
      phase_q <= phase_d;
      last_q  <= last_d;
      first_q <= first_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      viol_q  <= viol_d;
      cyc_q   <= cyc_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign phase       = phase_q;
  assign viol_count  = viol_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: two monitors (all-red forbidden / one all-red sample allowed)
// driven by the same bus, checked against a per-direction rule model.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  localparam int GMIN = 10, GMAX = 10, YMIN = 3, YMAX = 3;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  typedef struct {
    logic        fault;
    logic [2:0]  code;
    logic [2:0]  phase;
    logic [7:0]  viol;
    logic [15:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       fault_clr = 1'b0;
  logic [2:0] ns = 3'b100;
  logic [2:0] ew = 3'b100;
  logic        fault_o [2];
  logic [2:0]  code_o  [2];
  logic [2:0]  phase_o [2];
  logic [7:0]  viol_o  [2];
  logic [15:0] cyc_o   [2];

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  // reference model state, one slot per DUT
  bit         m_sync [2];
  logic [2:0] m_ns   [2];
  logic [2:0] m_ew   [2];
  int         m_dwell[2];
  int         m_last [2];   // 0 none, 1 NS, 2 EW
  bit         m_first[2];
  bit         m_fault[2];
  int         m_code [2];
  int         m_viol [2];
  int         m_cyc  [2];

  always #5 clk = ~clk;

  traffic_light_monitor #(.GRN_MIN(GMIN), .GRN_MAX(GMAX), .YEL_MIN(YMIN), .YEL_MAX(YMAX),
                          .ALLRED_MAX(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .ns(ns), .ew(ew), .fault_clr(fault_clr),
    .fault(fault_o[0]), .fault_code(code_o[0]), .phase(phase_o[0]),
    .viol_count(viol_o[0]), .cycle_count(cyc_o[0]));

  traffic_light_monitor #(.GRN_MIN(GMIN), .GRN_MAX(GMAX), .YEL_MIN(YMIN), .YEL_MAX(YMAX),
                          .ALLRED_MAX(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .ns(ns), .ew(ew), .fault_clr(fault_clr),
    .fault(fault_o[1]), .fault_code(code_o[1]), .phase(phase_o[1]),
    .viol_count(viol_o[1]), .cycle_count(cyc_o[1]));

  function automatic int amax(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic bit legal(input logic [2:0] l);
    return (l == R) || (l == Y) || (l == G);
  endfunction

  function automatic bit ok_tr(input logic [2:0] p, input logic [2:0] c);
    return (c == p) || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G);
  endfunction

  function automatic bit short_exit(input logic [2:0] p, input logic [2:0] c,
                                    input int dwell, input bit first);
    int mn;
    mn = (p == G) ? GMIN : YMIN;
    return (p != R) && (c != p) && (dwell < mn) && !(first && p == G);
  endfunction

  task automatic cmp(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sync[i] = 0; m_ns[i] = R; m_ew[i] = R; m_dwell[i] = 0; m_last[i] = 0;
      m_first[i] = 0; m_fault[i] = 0; m_code[i] = 0; m_viol[i] = 0; m_cyc[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [2:0] s_ns, input logic [2:0] s_ew, input logic clr);
    int code, last_new, mx;
    bit same, all_red;
    exp_t e;
    code = 0;
    all_red = (s_ns == R) && (s_ew == R);
    if (!legal(s_ns) || !legal(s_ew)) code = 1;
    else if (s_ns != R && s_ew != R) code = 2;
    else if (m_sync[i]) begin
      same = (s_ns == m_ns[i]) && (s_ew == m_ew[i]);
      last_new = m_last[i];
      if (m_ns[i] == Y && s_ns == R) last_new = 1;
      if (m_ew[i] == Y && s_ew == R) last_new = 2;
      mx = ((s_ns == G) || (s_ew == G)) ? GMAX : YMAX;
      if (!ok_tr(m_ns[i], s_ns) || !ok_tr(m_ew[i], s_ew)) code = 3;
      else if ((m_ns[i] == R && s_ns == G && last_new == 1) ||
               (m_ew[i] == R && s_ew == G && last_new == 2)) code = 4;
      else if (short_exit(m_ns[i], s_ns, m_dwell[i], m_first[i]) ||
               short_exit(m_ew[i], s_ew, m_dwell[i], m_first[i])) code = 5;
      else if (same && !all_red && m_dwell[i] >= mx) code = 6;
      else if (all_red && (same ? m_dwell[i] + 1 : 1) > amax(i)) code = 7;
      if (code == 0) begin
        if (m_ns[i] == R && s_ns == G && last_new == 2) m_cyc[i] = (m_cyc[i] + 1) % 65536;
        m_dwell[i] = same ? m_dwell[i] + 1 : 1;
        if (!same) m_first[i] = 0;
        m_last[i] = last_new;
        m_ns[i] = s_ns;
        m_ew[i] = s_ew;
      end
    end else if ((s_ns == G && s_ew == R) || (s_ns == R && s_ew == G)) begin
      m_sync[i] = 1; m_ns[i] = s_ns; m_ew[i] = s_ew; m_dwell[i] = 1; m_first[i] = 1;
    end
    if (code != 0) begin
      m_sync[i] = 0;
      if (m_viol[i] < 255) m_viol[i]++;
      if (!m_fault[i] || clr) begin m_fault[i] = 1; m_code[i] = code; end
    end else if (clr) begin
      m_fault[i] = 0; m_code[i] = 0;
    end
    e.fault = m_fault[i];
    e.code  = 3'(m_code[i]);
    e.viol  = 8'(m_viol[i]);
    e.cyc   = 16'(m_cyc[i]);
    if (!m_sync[i])        e.phase = 3'd0;
    else if (m_ns[i] == G) e.phase = 3'd1;
    else if (m_ns[i] == Y) e.phase = 3'd2;
    else if (m_ew[i] == G) e.phase = 3'd3;
    else if (m_ew[i] == Y) e.phase = 3'd4;
    else                   e.phase = 3'd5;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic c);
    ns = a; ew = b; fault_clr = c;
    model_step(0, a, b, c);
    model_step(1, a, b, c);
  endtask

  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic c);
    @(negedge clk);
    drive(a, b, c);
  endtask

  task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
    repeat (n) step(a, b, 1'b0);
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      cmp({name, "_fault"}, i, 16'(fault_o[i]), 16'd0);
      cmp({name, "_code"},  i, 16'(code_o[i]),  16'd0);
      cmp({name, "_phase"}, i, 16'(phase_o[i]), 16'd0);
      cmp({name, "_viol"},  i, 16'(viol_o[i]),  16'd0);
      cmp({name, "_cyc"},   i, cyc_o[i],        16'd0);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    drive(R, R, 1'b0);
  endtask

  task automatic rand_sample(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] rn, re;
    logic c;
    rn = a; re = b;
    if ($urandom_range(0, 39) == 0) begin
      rn = 3'($urandom_range(0, 7));
      re = 3'($urandom_range(0, 7));
    end
    c = ($urandom_range(0, 24) == 0);
    step(rn, re, c);
  endtask

  task automatic random_rounds(input int n);
    int dir, r, glen, ylen;
    dir = 0;
    repeat (n) begin
      if ($urandom_range(0, 7) != 0) dir = 1 - dir;
      r = $urandom_range(0, 9);
      glen = (r == 0) ? GMIN - 1 : (r == 1) ? GMAX + 1 : GMIN;
      r = $urandom_range(0, 9);
      ylen = (r == 0) ? YMIN - 1 : (r == 1) ? YMAX + 1 : YMIN;
      repeat (glen) rand_sample((dir == 0) ? G : R, (dir == 0) ? R : G);
      repeat (ylen) rand_sample((dir == 0) ? Y : R, (dir == 0) ? R : Y);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 2)) rand_sample(R, R);
    end
  endtask

  // Monitor: each edge after a driven sample, pop and compare both DUTs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("fault", 0, 16'(fault_o[0]), 16'(e.fault));
        cmp("code",  0, 16'(code_o[0]),  16'(e.code));
        cmp("phase", 0, 16'(phase_o[0]), 16'(e.phase));
        cmp("viol",  0, 16'(viol_o[0]),  16'(e.viol));
        cmp("cyc",   0, cyc_o[0],        e.cyc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("fault", 1, 16'(fault_o[1]), 16'(e.fault));
        cmp("code",  1, 16'(code_o[1]),  16'(e.code));
        cmp("phase", 1, 16'(phase_o[1]), 16'(e.phase));
        cmp("viol",  1, 16'(viol_o[1]),  16'(e.viol));
        cmp("cyc",   1, cyc_o[1],        e.cyc);
      end
    end
  end

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_zero("reset");
    release_reset();

    // nominal: four full NS/EW cycles
    repeat (4) begin
      hold(G, R, 10); hold(Y, R, 3); hold(R, G, 10); hold(R, Y, 3);
    end
    // conflict during NS green, then resync
    hold(G, R, 5);
    step(G, G, 1'b0);
    hold(G, R, 10);
    step(Y, R, 1'b1);
    hold(Y, R, 2);
    // encoding outranks conflict
    step(3'b011, G, 1'b0);
    // short yellow with fault already set, then long green after a clear
    hold(G, R, 10); hold(Y, R, 3); hold(R, G, 10); hold(R, Y, 2);
    step(G, R, 1'b0);
    step(G, R, 1'b1);
    hold(G, R, 10);
    // G->R sequence fault
    hold(G, R, 5);
    step(R, R, 1'b0);
    // all-red stall (dut0) versus same-direction green order fault (dut1)
    step(G, R, 1'b1);
    hold(G, R, 9); hold(Y, R, 3);
    step(R, R, 1'b0);
    step(G, R, 1'b0);
    // clear coinciding with a conflict keeps the new code
    hold(G, R, 3);
    step(G, G, 1'b1);
    // asynchronous reset in the middle of EW green
    hold(R, G, 4);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    release_reset();

    random_rounds(40);

    repeat (3) @(negedge clk);
    cmp("q0_drained", 0, 16'(q0.size()), 16'd0);
    cmp("q1_drained", 1, 16'(q1.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
